// File: rtl/pipe5_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe5_stage_pkg
// Brief    : Shared types for pipe5 inter-stage elastic buffers.
// Revision : 1.0
// ============================================================================
package pipe5_stage_pkg;

   // Packed execute->memory bundle, sized to exactly 256 bits.
   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] alu_result;
      logic [63:0] store_data;
      logic [4:0]  rd;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic [2:0]  funct3;
      logic [52:0] rsvd;
   } ex_mem_bundle_t;

   localparam int EX_MEM_W = $bits(ex_mem_bundle_t);

   localparam logic BUBBLE = 1'b0;

   typedef enum logic [1:0] {
      MODE_EMPTY   = 2'd0,
      MODE_PARTIAL = 2'd1,
      MODE_FULL    = 2'd2
   } stage_mode_t;

endpackage
`default_nettype wire

// File: rtl/pipe_elastic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_elastic_ctrl
// Brief    : Pointer, occupancy and flush-drop bookkeeping for the elastic stage.
// Revision : 1.0
// ============================================================================
module pipe_elastic_ctrl
   import pipe5_stage_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             in_valid,
   input  logic             out_ready,
   input  logic             flush,
   output logic             in_ready,
   output logic             out_valid,
   output logic             wr_en,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [OCC_W-1:0] occupancy,
   output logic [CNT_W-1:0] flush_drops
);

   localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [OCC_W-1:0] r_count;
   logic [CNT_W-1:0] r_drops;

   stage_mode_t      w_mode;
   logic             w_push;
   logic             w_pop;
   logic [OCC_W-1:0] w_drop;
   logic [SUM_W-1:0] w_sum;
   logic [CNT_W-1:0] w_drops_next;

   always_comb begin
      w_mode = MODE_PARTIAL;
      if (r_count == '0)
         w_mode = MODE_EMPTY;
      else if (r_count == OCC_W'(DEPTH))
         w_mode = MODE_FULL;
   end

   // Handshake flags come from registered state only, so no ready chain forms.
   assign in_ready  = (w_mode != MODE_FULL);
   assign out_valid = (w_mode != MODE_EMPTY);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   assign wr_en     = w_push & ~flush;

   // A head popped during the flush cycle was delivered, so it is not a drop.
   assign w_drop       = r_count - OCC_W'(w_pop);
   assign w_sum        = SUM_W'(r_drops) + SUM_W'(w_drop);
   assign w_drops_next = (w_sum > SUM_W'(c_cnt_max)) ? c_cnt_max : w_sum[CNT_W-1:0];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_drops  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_drops  <= w_drops_next;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + OCC_W'(1);
            2'b01:   r_count <= r_count - OCC_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign wr_ptr      = r_wr_ptr;
   assign rd_ptr      = r_rd_ptr;
   assign occupancy   = r_count;
   assign flush_drops = r_drops;

endmodule
`default_nettype wire

// File: rtl/pipe_elastic_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_elastic_stage
// Brief    : DEPTH-entry elastic pipeline register with flush and drop counter.
// Revision : 1.0
// ============================================================================
module pipe_elastic_stage
   import pipe5_stage_pkg::*;
#(
   parameter int DATA_W = EX_MEM_W,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [OCC_W-1:0]  occupancy,
   output logic [CNT_W-1:0]  flush_drops
);

   logic              w_wr_en;
   logic [PTR_W-1:0]  w_wr_ptr;
   logic [PTR_W-1:0]  w_rd_ptr;
   logic [DATA_W-1:0] r_mem [DEPTH];

   pipe_elastic_ctrl #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_ctrl (
      .CLK         (CLK),
      .nRST        (nRST),
      .in_valid    (in_valid),
      .out_ready   (out_ready),
      .flush       (flush),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .wr_en       (w_wr_en),
      .wr_ptr      (w_wr_ptr),
      .rd_ptr      (w_rd_ptr),
      .occupancy   (occupancy),
      .flush_drops (flush_drops)
   );

   // Storage is deliberately unreset; out_valid gates every read.
   always_ff @(posedge CLK) begin
      if (w_wr_en)
         r_mem[w_wr_ptr] <= in_data;
   end

   assign out_data = out_valid ? r_mem[w_rd_ptr] : {DATA_W{BUBBLE}};

   a_hold_valid: assert property (@(posedge CLK) disable iff (!nRST)
      (in_valid && !in_ready && !flush) |=> in_valid);

   a_hold_data: assert property (@(posedge CLK) disable iff (!nRST)
      (in_valid && !in_ready && !flush) |=> $stable(in_data));

endmodule
`default_nettype wire

// File: tb/tb_pipe_elastic_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_elastic_stage
// Brief    : Scoreboard bench for pipe_elastic_stage at DEPTH=2 and DEPTH=4.
// Revision : 1.0
// ============================================================================
module tb_pipe_elastic_stage;

   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         nrst;

   logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
   logic [W-1:0] a_in_data, a_out_data;
   logic [1:0]   a_occ;
   logic [15:0]  a_drops;

   logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
   logic [W-1:0] b_in_data, b_out_data;
   logic [2:0]   b_occ;
   logic [1:0]   b_drops;

   int passed = 0;
   int total  = 0;

   logic [W-1:0] qa [$];
   logic [W-1:0] qb [$];

   pipe_elastic_stage #(.DATA_W(W), .DEPTH(2), .CNT_W(16)) u_dut_a (
      .CLK(clk), .nRST(nrst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .flush(a_flush), .occupancy(a_occ), .flush_drops(a_drops)
   );

   pipe_elastic_stage #(.DATA_W(W), .DEPTH(4), .CNT_W(2)) u_dut_b (
      .CLK(clk), .nRST(nrst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .flush(b_flush), .occupancy(b_occ), .flush_drops(b_drops)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitors: every completed pop must match the queue head in order.
   always @(negedge clk) begin
      if (nrst) begin
         if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
               total++;
               $display("FAIL a_pop: unexpected bundle 0x%0h, expected none", a_out_data);
            end else
               chk("a_pop", a_out_data, qa.pop_front());
         end else if (!a_out_valid)
            chk("a_bubble", a_out_data, '0);
      end
   end

   always @(negedge clk) begin
      if (nrst) begin
         if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
               total++;
               $display("FAIL b_pop: unexpected bundle 0x%0h, expected none", b_out_data);
            end else
               chk("b_pop", b_out_data, qb.pop_front());
         end else if (!b_out_valid)
            chk("b_bubble", b_out_data, '0);
      end
   end

   initial begin
      logic [1:0] sat_exp [3];
      sat_exp = '{2'd2, 2'd3, 2'd3};

      nrst = 1'b0;
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0; a_in_data = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0; b_in_data = '0;
      repeat (3) step();
      nrst = 1'b1;
      step();

      chk("rst_out_valid", 32'(a_out_valid), 0);
      chk("rst_in_ready",  32'(a_in_ready), 1);
      chk("rst_occ",       32'(a_occ), 0);
      chk("rst_drops",     32'(a_drops), 0);
      chk("rst_out_data",  a_out_data, 0);

      // Streaming at DEPTH=2: one bundle per cycle, first visible one cycle later.
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         a_in_data = 32'(i);
         qa.push_back(32'(i));
         step();
         if (i == 1) begin
            chk("stream_lat_valid", 32'(a_out_valid), 1);
            chk("stream_lat_data",  a_out_data, 1);
         end
         chk("stream_occ", 32'(a_occ), 1);
      end
      a_in_valid = 1'b0;
      step();
      chk("stream_drain_occ", 32'(a_occ), 0);

      // Back-pressure: 0xA,0xB fill the buffer, 0xC waits.
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data = 32'hA; qa.push_back(32'hA); step();
      chk("bp_ready_1", 32'(a_in_ready), 1);
      a_in_data = 32'hB; qa.push_back(32'hB); step();
      chk("bp_ready_full", 32'(a_in_ready), 0);
      chk("bp_occ_full",   32'(a_occ), 2);
      a_in_data = 32'hC; qa.push_back(32'hC); step();
      chk("bp_ready_held", 32'(a_in_ready), 0);
      step();
      chk("bp_head_held", a_out_data, 32'hA);
      a_out_ready = 1'b1;
      #1;
      chk("bp_no_ready_chain", 32'(a_in_ready), 0);
      step();
      chk("bp_occ_after_pop", 32'(a_occ), 1);
      chk("bp_head_b",        a_out_data, 32'hB);
      step();
      chk("bp_head_c", a_out_data, 32'hC);
      chk("bp_occ_c",  32'(a_occ), 1);
      a_in_valid = 1'b0;
      step();
      chk("bp_drain_occ", 32'(a_occ), 0);

      // Flush a full buffer with a push pending and no pop.
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data = 32'h11; step();
      a_in_data = 32'h22; step();
      a_in_data = 32'h33; a_flush = 1'b1; step();
      a_flush = 1'b0; a_in_valid = 1'b0;
      chk("flush_occ",      32'(a_occ), 0);
      chk("flush_valid",    32'(a_out_valid), 0);
      chk("flush_drops",    32'(a_drops), 2);
      chk("flush_out_data", a_out_data, 0);
      a_out_ready = 1'b1;
      repeat (3) step();
      chk("flush_stays_empty", 32'(a_occ), 0);

      // Flush with a simultaneous pop: head is delivered, only one entry dropped.
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data = 32'h44; step();
      a_in_data = 32'h55; step();
      a_in_valid = 1'b0;
      qa.push_back(32'h44);
      a_flush = 1'b1; a_out_ready = 1'b1; step();
      a_flush = 1'b0;
      chk("flushpop_drops", 32'(a_drops), 3);
      chk("flushpop_occ",   32'(a_occ), 0);
      chk("flushpop_valid", 32'(a_out_valid), 0);
      step();

      // Asynchronous reset with two entries held.
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data = 32'h66; step();
      a_in_data = 32'h77; step();
      a_in_valid = 1'b0;
      chk("pre_rst_occ", 32'(a_occ), 2);
      #2;
      nrst = 1'b0;
      #1;
      chk("arst_out_valid", 32'(a_out_valid), 0);
      chk("arst_in_ready",  32'(a_in_ready), 1);
      chk("arst_occ",       32'(a_occ), 0);
      chk("arst_drops",     32'(a_drops), 0);
      chk("arst_out_data",  a_out_data, 0);
      step();
      nrst = 1'b1;
      step();

      // DEPTH=4: ten bundles through wrapping pointers at occupancy 3.
      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) b_out_ready = 1'b1;
         b_in_data = 32'h100 + 32'(i);
         qb.push_back(32'h100 + 32'(i));
         step();
      end
      chk("wrap_occ", 32'(b_occ), 3);
      b_in_valid = 1'b0;
      repeat (3) step();
      chk("wrap_drain_occ", 32'(b_occ), 0);

      // DEPTH=4 full boundary.
      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b_in_data = 32'h200 + 32'(i);
         qb.push_back(32'h200 + 32'(i));
         step();
      end
      chk("full4_ready", 32'(b_in_ready), 0);
      chk("full4_occ",   32'(b_occ), 4);
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;
      repeat (4) step();
      chk("full4_drain_occ",   32'(b_occ), 0);
      chk("full4_drain_ready", 32'(b_in_ready), 1);

      // Three flushes of two entries each saturate a 2-bit counter at 3.
      for (int k = 0; k < 3; k++) begin
         b_out_ready = 1'b0;
         b_in_valid  = 1'b1;
         b_in_data = 32'h300 + 32'(2 * k);     step();
         b_in_data = 32'h300 + 32'(2 * k + 1); step();
         b_in_valid = 1'b0;
         b_flush = 1'b1; step();
         b_flush = 1'b0;
         chk("sat_drops", 32'(b_drops), 32'(sat_exp[k]));
         chk("sat_occ",   32'(b_occ), 0);
      end

      step();
      chk("a_queue_empty", 32'(qa.size()), 0);
      chk("b_queue_empty", 32'(qb.size()), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
